// File: rtl/riscv_mem_responder_pkg.sv
// riscv_mem_responder_pkg: shared state encoding, NOP word and default depths
package riscv_mem_responder_pkg;
    typedef enum logic {LOAD, RUN} state_t;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam int DEF_IMEM_WORDS = 64;
    localparam int DEF_DMEM_WORDS = 64;
endpackage

// File: rtl/riscv_mem_responder_word_ram.sv
// word_ram: 32-bit word array, one synchronous write port, one combinational read port
module word_ram #(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder: boot-loads instruction memory, then serves core fetches and data accesses
module riscv_mem_responder
    import riscv_mem_responder_pkg::*;
#(
    parameter int IMEM_WORDS = DEF_IMEM_WORDS,
    parameter int DMEM_WORDS = DEF_DMEM_WORDS
) (
    input  logic        clk,
    input  logic        rset,
    input  logic [31:0] pc,
    output logic [31:0] ins,
    input  logic        dm_we,
    input  logic [7:0]  MEM_addr,
    input  logic [31:0] MEM_wDATA,
    output logic [31:0] MEM_rData,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        core_rst,
    output logic        err_misaligned
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);
    localparam int WW  = IAW + 1;

    state_t          r_state, w_state_nxt;
    logic [WW-1:0]   r_wptr;
    logic            r_err;
    logic            w_load, w_hs, w_done, w_pc_mis, w_st_mis, w_pc_in, w_d_in, w_dm_we;
    logic [31:0]     w_imem_rd, w_dmem_rd;

    assign w_load   = r_state == LOAD;
    assign ld_ready = w_load & ~rset;
    assign core_rst = w_load | rset;
    assign w_hs     = ld_valid & ld_ready;
    assign w_done   = w_hs & (ld_last | r_wptr == WW'(IMEM_WORDS - 1));
    assign w_pc_mis = pc[1:0] != 2'b00;
    assign w_st_mis = dm_we & (MEM_addr[1:0] != 2'b00);
    assign w_pc_in  = {2'b00, pc[31:2]} < 32'(IMEM_WORDS);
    assign w_d_in   = {26'd0, MEM_addr[7:2]} < 32'(DMEM_WORDS);
    assign w_dm_we  = ~w_load & ~rset & dm_we & ~w_st_mis & w_d_in;

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = rset ? LOAD : (w_done ? RUN : r_state);
    end

    always_ff @(posedge clk) begin
        r_state <= w_state_nxt;
        r_wptr  <= rset ? '0 : (w_hs ? r_wptr + WW'(1) : r_wptr);
        // the flag is sticky: only reset clears it
        r_err   <= rset ? 1'b0 : (r_err | (~w_load & (w_pc_mis | w_st_mis)));
    end

    word_ram #(.DEPTH(IMEM_WORDS)) u_imem (
        .clk     (clk),
        .i_we    (w_hs),
        .i_waddr (r_wptr[IAW-1:0]),
        .i_wdata (ld_data),
        .i_raddr (pc[IAW+1:2]),
        .o_rdata (w_imem_rd)
    );

    word_ram #(.DEPTH(DMEM_WORDS)) u_dmem (
        .clk     (clk),
        .i_we    (w_dm_we),
        .i_waddr (MEM_addr[DAW+1:2]),
        .i_wdata (MEM_wDATA),
        .i_raddr (MEM_addr[DAW+1:2]),
        .o_rdata (w_dmem_rd)
    );

    assign ins            = (w_load | w_pc_mis | ~w_pc_in) ? NOP : w_imem_rd;
    assign MEM_rData      = w_d_in ? w_dmem_rd : 32'd0;
    assign err_misaligned = r_err;
endmodule

// File: doc/riscv_mem_responder.md
RISCV_MEM_RESPONDER -- requirements
Module: riscv_mem_responder

Interface
REQ-001 Parameter IMEM_WORDS, default 64, instruction memory depth in 32-bit words.
REQ-002 Parameter DMEM_WORDS, default 64, data memory depth in 32-bit words; the 8-bit byte address reaches 64 words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rset  input  1  reset, synchronous, active-high.
REQ-005 pc  input  32  core instruction byte address.
REQ-006 ins  output  32  instruction word returned to core.
REQ-007 dm_we  input  1  core data-store strobe.
REQ-008 MEM_addr  input  8  core data byte address.
REQ-009 MEM_wDATA  input  32  core store data.
REQ-010 MEM_rData  output  32  load data returned to core.
REQ-011 ld_valid  input  1  boot-loader word valid.
REQ-012 ld_data  input  32  boot-loader instruction word.
REQ-013 ld_last  input  1  marks final boot-loader word.
REQ-014 ld_ready  output  1  responder accepts a loader word.
REQ-015 core_rst  output  1  holds core in reset while loading.
REQ-016 err_misaligned  output  1  sticky misaligned-access flag.

Function
REQ-017 FSM states: LOAD, RUN; no other states.
REQ-018 LOAD: ld_ready=1, core_rst=1, ins=NOP (32'h00000013), data writes ignored.
REQ-019 LOAD, handshake = ld_valid&ld_ready: write ld_data to imem[wptr], wptr+1 on the same edge.
REQ-020 LOAD->RUN on handshake with ld_last=1, or handshake at wptr==IMEM_WORDS-1 (full); no wrap; further words never accepted.
REQ-021 ld_valid without ld_ready never writes; ld_data may change while ld_valid=0.
REQ-022 RUN: ld_ready=0, core_rst=0; stays in RUN until rset.
REQ-023 ins combinational: imem[pc>>2] when pc[1:0]==0 and pc>>2 < IMEM_WORDS; else NOP.
REQ-024 pc[1:0]!=0 in RUN: ins=NOP, err_misaligned set next edge.
REQ-025 MEM_rData combinational = dmem[MEM_addr[7:2]], masked to 0 when index >= DMEM_WORDS.
REQ-026 Store: in RUN, dm_we=1 and MEM_addr[1:0]==0 and index in range -> dmem[MEM_addr[7:2]] <= MEM_wDATA at edge.
REQ-027 Store with MEM_addr[1:0]!=0: suppressed, err_misaligned set next edge; out-of-range store silently dropped.
REQ-028 Same-cycle store and load to same word: MEM_rData shows old value that cycle, new value the cycle after.
REQ-029 err_misaligned stays 1 until rset.
REQ-030 Loader words 0..n-1 are the only imem words defined by this load; unloaded words keep prior contents.

Reset
REQ-031 rset=1 at an edge: state=LOAD, wptr=0, err_misaligned=0; core_rst=1, ld_ready=1 from the next cycle.
REQ-032 Reset mid-LOAD restarts at wptr=0; reset in RUN re-enters LOAD; memory array contents not cleared.
REQ-033 While rset=1: core_rst=1, ld_ready=0, no memory writes.

Structure
REQ-034 Shared package holds state enum {LOAD,RUN}, NOP constant 32'h00000013, default depth constants.
REQ-035 One sub-module word_ram (1 write port, 1 combinational read port, parameter depth), instantiated for imem and dmem.

Verification
REQ-036 Load 3 words, last on word 2 -> wptr stops at 3, RUN next cycle, core_rst 1->0, pc=8 returns word 2.
REQ-037 Stream IMEM_WORDS words without ld_last -> RUN after word 63, ld_ready=0, word 64 not accepted.
REQ-038 RUN, dm_we=1, MEM_addr=8'h10, MEM_wDATA=32'hDEADBEEF -> MEM_rData old that cycle, DEADBEEF next cycle at 8'h10.
REQ-039 dm_we=1, MEM_addr=8'h12 -> dmem word 4 unchanged, err_misaligned=1 until rset.
REQ-040 rset pulse after 2 loaded words -> LOAD, wptr=0, err cleared, reload overwrites imem[0].
REQ-041 pc=32'h00000102 or pc=32'h00000400 -> ins=32'h00000013; former also sets err_misaligned.
